// File: rtl/storage_wb_port.sv
// storage_wb_port
//   Wishbone-classic slave that drives the management storage array. A bus cycle
//   is decoded into one cycle of SRAM strobes (R/W blocks or the block-0 RO port).
//   The port then waits out the one-cycle SRAM read latency and returns registered
//   read data with a single-cycle acknowledge.
// Ports:
//   mgmt_clk, mgmt_rst           clock, asynchronous active-high reset
//   wb_*                         Wishbone slave (cyc/stb/we/sel/adr/dat_i, dat_o/ack_o)
//   mgmt_ena/wen/wen_mask        per-block strobes (ena/wen active low, mask active high)
//   mgmt_addr/wdata              shared word address and write data for the R/W port
//   mgmt_rdata                   per-block read data, block b at [32b+31:32b]
//   mgmt_ena_ro/addr_ro/rdata_ro block-0 read-only port
module storage_wb_port #(
   parameter int unsigned RAM_BLOCKS = 2,
   parameter logic [7:0]  RW_BASE    = 8'h01,
   parameter logic [7:0]  RO_BASE    = 8'h02
) (
   input  logic                    mgmt_clk,
   input  logic                    mgmt_rst,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [3:0]              wb_sel_i,
   input  logic [31:0]             wb_adr_i,
   input  logic [31:0]             wb_dat_i,
   output logic [31:0]             wb_dat_o,
   output logic                    wb_ack_o,
   output logic [RAM_BLOCKS-1:0]   mgmt_ena,
   output logic [RAM_BLOCKS-1:0]   mgmt_wen,
   output logic [RAM_BLOCKS*4-1:0] mgmt_wen_mask,
   output logic [7:0]              mgmt_addr,
   output logic [31:0]             mgmt_wdata,
   input  logic [RAM_BLOCKS*32-1:0] mgmt_rdata,
   output logic                    mgmt_ena_ro,
   output logic [7:0]              mgmt_addr_ro,
   input  logic [31:0]             mgmt_rdata_ro
);

   typedef enum logic [1:0] {StIdle, StAccess, StRwait, StAck} state_e;

   state_e                  state_q, state_d;
   logic                    ack_q, ack_d;
   logic [31:0]             dat_q, dat_d;
   logic [RAM_BLOCKS-1:0]   ena_q, ena_d;
   logic [RAM_BLOCKS-1:0]   wen_q, wen_d;
   logic [RAM_BLOCKS*4-1:0] mask_q, mask_d;
   logic [7:0]              addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    ena_ro_q, ena_ro_d;
   logic [7:0]              addr_ro_q, addr_ro_d;
   // Decode captured at the start of the transaction
   logic                    we_q, we_d;
   logic                    rw_q, rw_d;
   logic                    ro_q, ro_d;
   logic [1:0]              blk_q, blk_d;

   logic       rw_hit, ro_hit;
   logic [1:0] blk_idx;
   logic [7:0] word_addr;
   logic       unused_adr;

   assign blk_idx    = wb_adr_i[11:10];
   assign word_addr  = wb_adr_i[9:2];
   assign rw_hit     = (wb_adr_i[31:24] == RW_BASE) && (wb_adr_i[23:12] == 12'h0) &&
                       (32'(blk_idx) < RAM_BLOCKS);
   assign ro_hit     = (wb_adr_i[31:24] == RO_BASE) && (wb_adr_i[23:10] == 14'h0);
   assign unused_adr = ^wb_adr_i[1:0];

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      dat_d     = dat_q;
      ena_d     = '1;
      wen_d     = '1;
      mask_d    = '0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ena_ro_d  = 1'b1;
      addr_ro_d = addr_ro_q;
      we_d      = we_q;
      rw_d      = rw_q;
      ro_d      = ro_q;
      blk_d     = blk_q;

      unique case (state_q)
         StIdle: begin
            if (wb_cyc_i && wb_stb_i) begin
               state_d = StAccess;
               we_d    = wb_we_i;
               rw_d    = rw_hit;
               ro_d    = ro_hit;
               blk_d   = blk_idx;
               // Strobes are registered here so they are live for exactly the ACCESS cycle.
               // A write with no byte selected touches nothing but is still acked.
               if (rw_hit && (!wb_we_i || (wb_sel_i != 4'h0))) begin
                  addr_d = word_addr;
                  if (wb_we_i) wdata_d = wb_dat_i;
                  for (int unsigned b = 0; b < RAM_BLOCKS; b++) begin
                     if (blk_idx == 2'(b)) begin
                        ena_d[b] = 1'b0;
                        wen_d[b] = ~wb_we_i;
                        if (wb_we_i) mask_d[4*b +: 4] = wb_sel_i;
                     end
                  end
               end
               if (ro_hit && !wb_we_i) begin
                  ena_ro_d  = 1'b0;
                  addr_ro_d = word_addr;
               end
            end
         end
         StAccess: begin
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else if (we_q) begin
               state_d = StAck;
               ack_d   = 1'b1;
            end else begin
               state_d = StRwait;
            end
         end
         StRwait: begin
            // An abandoned read leaves wb_dat_o untouched.
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else begin
               state_d = StAck;
               ack_d   = 1'b1;
               dat_d   = 32'h0;
               if (rw_q) begin
                  for (int unsigned b = 0; b < RAM_BLOCKS; b++) begin
                     if (blk_q == 2'(b)) dat_d = mgmt_rdata[32*b +: 32];
                  end
               end else if (ro_q) begin
                  dat_d = mgmt_rdata_ro;
               end
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge mgmt_clk or posedge mgmt_rst) begin
      if (mgmt_rst) begin
         state_q   <= StIdle;
         ack_q     <= 1'b0;
         dat_q     <= 32'h0;
         ena_q     <= '1;
         wen_q     <= '1;
         mask_q    <= '0;
         addr_q    <= 8'h0;
         wdata_q   <= 32'h0;
         ena_ro_q  <= 1'b1;
         addr_ro_q <= 8'h0;
         we_q      <= 1'b0;
         rw_q      <= 1'b0;
         ro_q      <= 1'b0;
         blk_q     <= 2'h0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         ena_q     <= ena_d;
         wen_q     <= wen_d;
         mask_q    <= mask_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ena_ro_q  <= ena_ro_d;
         addr_ro_q <= addr_ro_d;
         we_q      <= we_d;
         rw_q      <= rw_d;
         ro_q      <= ro_d;
         blk_q     <= blk_d;
      end
   end

   assign wb_ack_o      = ack_q;
   assign wb_dat_o      = dat_q;
   assign mgmt_ena      = ena_q;
   assign mgmt_wen      = wen_q;
   assign mgmt_wen_mask = mask_q;
   assign mgmt_addr     = addr_q;
   assign mgmt_wdata    = wdata_q;
   assign mgmt_ena_ro   = ena_ro_q;
   assign mgmt_addr_ro  = addr_ro_q;

endmodule

// File: tb/tb_storage_wb_port.sv
// Bench for storage_wb_port (RAM_BLOCKS=2). Expected read data is queued when a
// read is issued and popped when the acknowledge arrives.
module tb_storage_wb_port;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0, dat_i = 32'h0;
   logic [31:0] dat_o;
   logic        ack;
   logic [1:0]  ena, wen;
   logic [7:0]  mask;
   logic [7:0]  maddr;
   logic [31:0] wdata;
   logic [63:0] rdata = 64'h0;
   logic        ena_ro;
   logic [7:0]  addr_ro;
   logic [31:0] rdata_ro = 32'h0;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   storage_wb_port #(
      .RAM_BLOCKS(2),
      .RW_BASE   (8'h01),
      .RO_BASE   (8'h02)
   ) dut (
      .mgmt_clk     (clk),
      .mgmt_rst     (rst),
      .wb_cyc_i     (cyc),
      .wb_stb_i     (stb),
      .wb_we_i      (we),
      .wb_sel_i     (sel),
      .wb_adr_i     (adr),
      .wb_dat_i     (dat_i),
      .wb_dat_o     (dat_o),
      .wb_ack_o     (ack),
      .mgmt_ena     (ena),
      .mgmt_wen     (wen),
      .mgmt_wen_mask(mask),
      .mgmt_addr    (maddr),
      .mgmt_wdata   (wdata),
      .mgmt_rdata   (rdata),
      .mgmt_ena_ro  (ena_ro),
      .mgmt_addr_ro (addr_ro),
      .mgmt_rdata_ro(rdata_ro)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ena"}, 64'(ena), 64'h3);
      check({tag, "_wen"}, 64'(wen), 64'h3);
      check({tag, "_mask"}, 64'(mask), 64'h0);
      check({tag, "_ena_ro"}, 64'(ena_ro), 64'h1);
   endtask

   task automatic check_reset(input string tag);
      check_idle(tag);
      check({tag, "_ack"}, 64'(ack), 64'h0);
      check({tag, "_dat"}, 64'(dat_o), 64'h0);
      check({tag, "_addr"}, 64'(maddr), 64'h0);
      check({tag, "_wdata"}, 64'(wdata), 64'h0);
      check({tag, "_addr_ro"}, 64'(addr_ro), 64'h0);
   endtask

   // One full bus transaction: strobes checked in ACCESS, then ack latency,
   // single-cycle ack and (for reads) returned data.
   task automatic xact(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] e_ena, input logic [1:0] e_wen,
                       input logic [7:0] e_mask, input logic [7:0] e_addr,
                       input logic e_ena_ro, input logic [7:0] e_addr_ro,
                       input logic [31:0] e_rd);
      int   n;
      logic got;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      if (!w) sb.push_back(e_rd);
      @(negedge clk);
      check({tag, "_ena"}, 64'(ena), 64'(e_ena));
      check({tag, "_wen"}, 64'(wen), 64'(e_wen));
      check({tag, "_mask"}, 64'(mask), 64'(e_mask));
      check({tag, "_ena_ro"}, 64'(ena_ro), 64'(e_ena_ro));
      check({tag, "_ack0"}, 64'(ack), 64'h0);
      if (e_ena != 2'b11) check({tag, "_addr"}, 64'(maddr), 64'(e_addr));
      if (e_ena != 2'b11 && w) check({tag, "_wdata"}, 64'(wdata), 64'(d));
      if (!e_ena_ro) check({tag, "_addr_ro"}, 64'(addr_ro), 64'(e_addr_ro));
      got = 1'b0;
      n   = 0;
      while (!got && n < 6) begin
         @(negedge clk);
         n++;
         if (n == 1) check_idle({tag, "_post"});
         if (ack) got = 1'b1;
      end
      if (!got) begin
         check({tag, "_ack_timeout"}, 64'h0, 64'h1);
      end else begin
         check({tag, "_latency"}, 64'(n), w ? 64'd1 : 64'd2);
         if (!w) check({tag, "_rdata"}, 64'(dat_o), 64'(sb.pop_front()));
      end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check({tag, "_ack_one"}, 64'(ack), 64'h0);
   endtask

   initial begin
      rdata    = {32'hCAFE_F00D, 32'h1111_2222};
      rdata_ro = 32'h1357_9BDF;
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      xact("wr_full", 1'b1, 32'h0100_0010, 32'hA5A5_1234, 4'hF,
           2'b10, 2'b10, 8'h0F, 8'h04, 1'b1, 8'h00, 32'h0);
      xact("rd_blk1", 1'b0, 32'h0100_0410, 32'h0, 4'hF,
           2'b01, 2'b11, 8'h00, 8'h04, 1'b1, 8'h00, 32'hCAFE_F00D);
      xact("wr_sel6", 1'b1, 32'h0100_0008, 32'h0BAD_BEEF, 4'h6,
           2'b10, 2'b10, 8'h06, 8'h02, 1'b1, 8'h00, 32'h0);
      xact("wr_sel0", 1'b1, 32'h0100_000C, 32'h1234_5678, 4'h0,
           2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 32'h0);
      xact("wr_blk1", 1'b1, 32'h0100_07F0, 32'h5555_AAAA, 4'h9,
           2'b01, 2'b01, 8'h90, 8'hFC, 1'b1, 8'h00, 32'h0);
      xact("rd_ro", 1'b0, 32'h0200_03FC, 32'h0, 4'hF,
           2'b11, 2'b11, 8'h00, 8'h00, 1'b0, 8'hFF, 32'h1357_9BDF);
      xact("rd_unmap", 1'b0, 32'h0300_0000, 32'h0, 4'hF,
           2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 32'h0);
      xact("rd_blk0", 1'b0, 32'h0100_0000, 32'h0, 4'hF,
           2'b10, 2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 32'h1111_2222);
      xact("rd_blk3", 1'b0, 32'h0100_0C00, 32'h0, 4'hF,
           2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 32'h0);
      xact("wr_ro", 1'b1, 32'h0200_0004, 32'hFFFF_FFFF, 4'hF,
           2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 32'h0);
      xact("rd_ro_hole", 1'b0, 32'h0200_0400, 32'h0, 4'hF,
           2'b11, 2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 32'h0);

      // cyc dropped while waiting for read data
      rdata = {32'hDEAD_BEEF, 32'h1111_2222};
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0100_0404; sel = 4'hF;
      @(negedge clk);
      check("abort_ena", 64'(ena), 64'h1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_ack", 64'(ack), 64'h0);
         check_idle("abort_idle");
      end
      xact("rd_after_abort", 1'b0, 32'h0100_0404, 32'h0, 4'hF,
           2'b01, 2'b11, 8'h00, 8'h01, 1'b1, 8'h00, 32'hDEAD_BEEF);

      // Reset pulsed while strobes are live
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0100_0010; dat_i = 32'h7777_8888;
      sel = 4'hF;
      @(negedge clk);
      check("rst_pre_ena", 64'(ena), 64'h2);
      rst = 1'b1;
      #1;
      check_reset("rst_async");
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_ack", 64'(ack), 64'h0);
         check_idle("rst_idle");
      end
      xact("rd_after_rst", 1'b0, 32'h0100_0000, 32'h0, 4'hF,
           2'b10, 2'b11, 8'h00, 8'h00, 1'b1, 8'h00, 32'h1111_2222);

      check("sb_empty", 64'(sb.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
